// File: rtl/exec_pkg.sv
// Shared types for the multi-cycle execute stage: opcodes, shifts, FSM states, flags.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_MUL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        HOLD = 2'b10
    } state_e;

    // Field order gives the {N,Z,V} bit layout seen on out_flags.
    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

endpackage

// File: rtl/exec_seq_mul.sv
// Iterative unsigned W x W multiplier, one shift-add step per cycle.
// Latency: start edge, then W iteration edges; done is high during the last iteration cycle.
// Backpressure: none; the caller decides when to read product after done.
module exec_seq_mul #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0]  cnt_q,    cnt_d;
    logic           run_q,    run_d;
    logic [2*W-1:0] acc_q,    acc_d;
    logic [2*W-1:0] mcand_q,  mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;

    // Load operands on start, otherwise perform one shift-add step while running.
    always_comb begin
        cnt_d    = cnt_q;
        run_d    = run_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done     = 1'b0;
        if (start) begin
            cnt_d    = '0;
            run_d    = 1'b1;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // The step committed at the coming edge is the W-th one.
            if (cnt_q == LAST) begin
                run_d = 1'b0;
                done  = 1'b1;
            end
        end
    end

    // Multiplier state registers; reset aborts any multiply in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: operand mux/shift, ALU, N/Z/V flags, registered result with iterative MUL.
// Latency: 1 cycle for ALU ops; W+1 cycles for MUL plus any downstream stall in HOLD.
// Backpressure: valid/ready; output held while out_valid && !out_ready, in_ready drops then.
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter int W    = 16,
    parameter int TAGW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [1:0]      in_shift,
    input  logic            in_asel,
    input  logic            in_bsel,
    input  logic [W-1:0]    in_rn,
    input  logic [W-1:0]    in_rm,
    input  logic [W-1:0]    in_imm,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_result,
    output logic [2:0]      out_flags,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_result_q, out_result_d;
    flags_t          out_flags_q, out_flags_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic [TAGW-1:0] mul_tag_q, mul_tag_d;

    logic [W-1:0]    a_opnd, b_opnd, rm_sh, alu_res;
    logic            alu_v;
    flags_t          alu_flags, mul_flags;
    logic            out_free, accept, is_mul, mul_start, mul_done, load;
    logic [2*W-1:0]  mul_prod;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op_e'(in_op) == OP_MUL);

    // Operand formation and single-cycle ALU with its flags.
    always_comb begin
        a_opnd = in_bsel ? in_imm : in_rn;
        case (shift_e'(in_shift))
            SH_LSL1: rm_sh = {in_rm[W-2:0], 1'b0};
            SH_LSR1: rm_sh = {1'b0, in_rm[W-1:1]};
            SH_ASR1: rm_sh = {in_rm[W-1], in_rm[W-1:1]};
            default: rm_sh = in_rm;
        endcase
        b_opnd = in_asel ? '0 : rm_sh;

        alu_v = 1'b0;
        case (op_e'(in_op))
            OP_SUB: begin
                alu_res = a_opnd - b_opnd;
                alu_v   = (a_opnd[W-1] != b_opnd[W-1]) && (alu_res[W-1] != a_opnd[W-1]);
            end
            OP_AND:  alu_res = a_opnd & b_opnd;
            OP_NOT:  alu_res = ~b_opnd;
            // ADD, and the unused encodings, which behave as ADD.
            default: begin
                alu_res = a_opnd + b_opnd;
                alu_v   = (a_opnd[W-1] == b_opnd[W-1]) && (alu_res[W-1] != a_opnd[W-1]);
            end
        endcase

        alu_flags   = '0;
        alu_flags.n = alu_res[W-1];
        alu_flags.z = (alu_res == '0);
        alu_flags.v = alu_v;

        // MUL overflow means the high half of the full product is nonzero.
        mul_flags   = '0;
        mul_flags.n = mul_prod[W-1];
        mul_flags.z = (mul_prod[W-1:0] == '0);
        mul_flags.v = |mul_prod[2*W-1:W];
    end

    exec_seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a_opnd),
        .b       (b_opnd),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM next state and output register load selection.
    always_comb begin
        state_d      = state_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_tag_d    = out_tag_q;
        mul_tag_d    = mul_tag_q;
        mul_start    = 1'b0;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        mul_tag_d = in_tag;
                        state_d   = MUL;
                    end else begin
                        load         = 1'b1;
                        out_result_d = alu_res;
                        out_flags_d  = alu_flags;
                        out_tag_d    = in_tag;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_free) begin
                    load         = 1'b1;
                    out_result_d = mul_prod[W-1:0];
                    out_flags_d  = mul_flags;
                    out_tag_d    = mul_tag_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new load keeps valid high even when the old result drains on the same edge.
        out_valid_d = load || (out_valid_q && !out_ready);
    end

    // Stage state and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_tag_q    <= '0;
            mul_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_tag_q    <= out_tag_d;
            mul_tag_q    <= mul_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_tag    = out_tag_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc with a result scoreboard.
// Latency: checks 1-cycle ALU and W+1-cycle MUL timing.
// Backpressure: exercises output stalls, reset abort and streaming.
module tb_exec_stage_mc;

    localparam int W    = 16;
    localparam int TAGW = 32;

    typedef struct {
        logic [W-1:0]    res;
        logic [2:0]      fl;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_asel, in_bsel;
    logic [2:0]      in_op;
    logic [1:0]      in_shift;
    logic [W-1:0]    in_rn, in_rm, in_imm;
    logic [TAGW-1:0] in_tag;
    logic            out_valid, out_ready, busy;
    logic [W-1:0]    out_result;
    logic [2:0]      out_flags;
    logic [TAGW-1:0] out_tag;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    exec_stage_mc #(.W(W), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_shift   (in_shift),
        .in_asel    (in_asel),
        .in_bsel    (in_bsel),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_imm     (in_imm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of one operation.
    function automatic exp_t model(input logic [2:0] op, input logic [1:0] sh,
                                   input logic asel, input logic bsel,
                                   input logic [W-1:0] rn, input logic [W-1:0] rm,
                                   input logic [W-1:0] imm, input logic [TAGW-1:0] tag);
        exp_t          e;
        logic [W-1:0]  a, b, s, r;
        logic [2*W-1:0] p;
        logic          v;
        a = bsel ? imm : rn;
        case (sh)
            2'b01:   s = rm << 1;
            2'b10:   s = rm >> 1;
            2'b11:   s = $unsigned($signed(rm) >>> 1);
            default: s = rm;
        endcase
        b = asel ? '0 : s;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        v = 1'b0;
        case (op)
            3'b001: begin r = a - b; v = (a[W-1] ^ b[W-1]) & (r[W-1] ^ a[W-1]); end
            3'b010: r = a & b;
            3'b011: r = ~b;
            3'b100: begin r = p[W-1:0]; v = (p[2*W-1:W] != 0); end
            default: begin r = a + b; v = ~(a[W-1] ^ b[W-1]) & (r[W-1] ^ a[W-1]); end
        endcase
        e.res = r;
        e.fl  = {r[W-1], (r == 0), v};
        e.tag = tag;
        return e;
    endfunction

    // Scoreboard: every transfer out of the stage is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", out_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", out_result, mon_e.res);
                chk("sb_flags",  out_flags,  mon_e.fl);
                chk("sb_tag",    out_tag,    mon_e.tag);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [1:0] sh, input logic asel,
                         input logic bsel, input logic [W-1:0] rn, input logic [W-1:0] rm,
                         input logic [W-1:0] imm, input logic [TAGW-1:0] tag);
        in_op    = op;
        in_shift = sh;
        in_asel  = asel;
        in_bsel  = bsel;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    // Wait for the accept edge, record the expectation, return just after that edge.
    task automatic wait_accept();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (in_ready)
            sb.push_back(model(in_op, in_shift, in_asel, in_bsel, in_rn, in_rm, in_imm, in_tag));
        else
            chk("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] sh, input logic asel,
                        input logic bsel, input logic [W-1:0] rn, input logic [W-1:0] rm,
                        input logic [W-1:0] imm, input logic [TAGW-1:0] tag);
        drive(op, sh, asel, bsel, rn, rm, imm, tag);
        wait_accept();
    endtask

    // Called right after a MUL accept edge; checks stall signals and W+1 latency.
    task automatic mul_check(input logic [W-1:0] er, input logic [2:0] ef);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            chk("mul_in_ready", in_ready, 1'b0);
            chk("mul_busy", busy, 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        chk("mul_latency", n, W + 1);
        chk("mul_result", out_result, er);
        chk("mul_flags", out_flags, ef);
        chk("mul_busy_end", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_shift  = '0;
        in_asel   = 1'b0;
        in_bsel   = 1'b0;
        in_rn     = '0;
        in_rm     = '0;
        in_imm    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",  out_valid,  1'b0);
        chk("rst_out_result", out_result, 16'h0000);
        chk("rst_out_flags",  out_flags,  3'b000);
        chk("rst_out_tag",    out_tag,    32'h0);
        chk("rst_busy",       busy,       1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // ADD overflow into the sign bit.
        send(3'b000, 2'b00, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 32'hA5A5_0001);
        chk("add_valid",  out_valid,  1'b1);
        chk("add_result", out_result, 16'h8000);
        chk("add_flags",  out_flags,  3'b101);
        chk("add_tag",    out_tag,    32'hA5A5_0001);
        @(posedge clk); #1;
        chk("add_drained", out_valid, 1'b0);

        // SUB with ASR1 of a negative Rm.
        send(3'b001, 2'b11, 1'b0, 1'b0, 16'h0002, 16'h8004, 16'h0000, 32'hA5A5_0002);
        chk("sub_result", out_result, 16'h4000);
        chk("sub_flags",  out_flags,  3'b000);
        @(posedge clk); #1;

        // Iterative multiplies.
        send(3'b100, 2'b00, 1'b0, 1'b0, 16'h0123, 16'h0010, 16'h0000, 32'hA5A5_0003);
        mul_check(16'h1230, 3'b000);
        @(posedge clk); #1;
        send(3'b100, 2'b00, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 32'hA5A5_0004);
        mul_check(16'h0000, 3'b011);
        @(posedge clk); #1;

        // Backpressure: stall an ADD result for five cycles with an AND waiting behind it.
        out_ready = 1'b0;
        send(3'b000, 2'b00, 1'b0, 1'b0, 16'h1234, 16'h0101, 16'h0000, 32'hA5A5_0005);
        drive(3'b010, 2'b00, 1'b0, 1'b1, 16'hFFFF, 16'h0FFF, 16'h00F0, 32'hA5A5_0006);
        repeat (5) begin
            chk("bp_valid",    out_valid,  1'b1);
            chk("bp_result",   out_result, 16'h1335);
            chk("bp_flags",    out_flags,  3'b000);
            chk("bp_tag",      out_tag,    32'hA5A5_0005);
            chk("bp_in_ready", in_ready,   1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept();
        chk("bp_and_valid",  out_valid,  1'b1);
        chk("bp_and_result", out_result, 16'h00F0);
        chk("bp_and_tag",    out_tag,    32'hA5A5_0006);
        @(posedge clk); #1;

        // Reset during a multiply abandons it.
        send(3'b100, 2'b00, 1'b0, 1'b0, 16'h00FF, 16'h00FF, 16'h0000, 32'hA5A5_0007);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy",  busy,      1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) begin
            chk("abort_no_out", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("abort_in_ready", in_ready, 1'b1);
        send(3'b011, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 32'hA5A5_0008);
        chk("not_result", out_result, 16'hFFFF);
        chk("not_flags",  out_flags,  3'b100);
        @(posedge clk); #1;

        // Back-to-back stream of four ADDs, the third with B forced to zero.
        for (int k = 0; k < 4; k++) begin
            drive(3'b000, 2'b00, (k == 2), 1'b0, 16'(16'h1000 * (k + 1)),
                  16'(16'h0011 * (k + 1)), 16'h0000, 32'(32'hB000_0000 + k));
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1'b1);
            if (k > 0) chk("stream_valid", out_valid, 1'b1);
            if (k == 3) chk("stream_asel_result", out_result, 16'h3000);
            if (in_ready)
                sb.push_back(model(in_op, in_shift, in_asel, in_bsel, in_rn, in_rm, in_imm, in_tag));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_valid_last", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("stream_valid_end", out_valid, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
